// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
// Optional lap support is selected with the STOPWATCH_CTRL_LAP_EN macro
// in stopwatch_ctrl.sv; this package is identical in both builds.
package stopwatch_pkg;

  // Sequencer state encoding, also driven straight onto the debug LEDs.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STOP = 2'b10;
  localparam logic [1:0] ST_LAP  = 2'b11;

  // Board defaults: 50 MHz clock, 100 Hz tick, 10 ms debounce window.
  localparam int DEF_TICK_DIV        = 500000;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

  // Button events that can act on the state machine.
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_CLEAR = 2'd1,
    EV_LAP   = 2'd2,
    EV_START = 2'd3
  } event_e;

  // Arbitration order for same-cycle presses, index 0 wins.
  localparam event_e EV_PRIORITY [3] = '{EV_START, EV_LAP, EV_CLEAR};

  // RUN and LAP are the counting states.
  function automatic logic is_running(input state_t st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

  // Highest-priority pressed event that is meaningful in state st.
  // Lap only matters while counting; clear only while not counting.
  function automatic event_e pick_event(input state_t st, input logic start_ev,
                                        input logic lap_ev, input logic clear_ev);
    event_e sel;
    logic   ok;
    sel = EV_NONE;
    for (int i = 2; i >= 0; i--) begin
      case (EV_PRIORITY[i])
        EV_START: ok = start_ev;
        EV_LAP:   ok = lap_ev && is_running(st);
        EV_CLEAR: ok = clear_ev && !is_running(st);
        default:  ok = 1'b0;
      endcase
      if (ok) sel = EV_PRIORITY[i];
    end
    return sel;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle press pulse on the accepted 1->0 (press) transition.
// Releases are debounced too but produce no pulse.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press_o
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Next-state: count while the synced level disagrees with the accepted
  // level, accept it once it has held for DEBOUNCE_CYCLES cycles.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_d;
  end

  // Registers; released (high) is the idle level.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions the start/stop, lap and clear
// buttons and runs the IDLE/RUN/STOP/LAP machine that drives the 100 Hz
// count tick, the counter clear and the display freeze.
// Define STOPWATCH_CTRL_LAP_EN to build with the lap button and LAP state;
// without it the lap key is ignored and freeze_o stays low.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_clear_n,
  output logic       tick_o,
  output logic       clear_o,
  output logic       freeze_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic start_ev, lap_ev, clear_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_start_n),
    .press_o  (start_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_clear_n),
    .press_o  (clear_ev)
  );

`ifdef STOPWATCH_CTRL_LAP_EN
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_lap_n),
    .press_o  (lap_ev)
  );
`else
  // Lap key has no function in this build.
  logic unused_key_lap_n;
  assign unused_key_lap_n = key_lap_n;
  assign lap_ev           = 1'b0;
`endif

  state_t        state_q, state_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          freeze_q, freeze_d;
  logic          running_q, running_d;
  logic [PW-1:0] presc_q, presc_d;
  event_e        ev;
  logic          advance;

  // Next-state: arbitrate events, step the FSM, derive registered outputs
  // from the next state and run the tick prescaler.
  always_comb begin
    ev      = pick_event(state_q, start_ev, lap_ev, clear_ev);
    state_d = state_q;
    clear_d = 1'b0;
    case (ev)
      EV_START: state_d = is_running(state_q) ? ST_STOP : ST_RUN;
`ifdef STOPWATCH_CTRL_LAP_EN
      EV_LAP:   state_d = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
`endif
      EV_CLEAR: begin
        state_d = ST_IDLE;
        clear_d = 1'b1;
      end
      default:  state_d = state_q;
    endcase

    running_d = is_running(state_d);
`ifdef STOPWATCH_CTRL_LAP_EN
    freeze_d  = (state_d == ST_LAP);
`else
    freeze_d  = 1'b0;
`endif

    // Count only while staying in a counting state, so the stop edge
    // never lets a tick slip into STOP; the held count keeps the
    // sub-tick phase for the next resume.
    advance = is_running(state_q) && is_running(state_d);
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clear_d) begin
      presc_d = '0;
    end else if (advance) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      freeze_q  <= 1'b0;
      running_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      freeze_q  <= freeze_d;
      running_q <= running_d;
      presc_q   <= presc_d;
    end
  end

  assign tick_o    = tick_q;
  assign clear_o   = clear_q;
  assign freeze_o  = freeze_q;
  assign running_o = running_q;
  assign state_o   = state_q;

endmodule
